// File: rtl/event_pkg.sv
// event_pkg: shared FSM state encoding and default widths for the spike dispatcher
package event_pkg;
    localparam int EV_ADDR_W   = 8;
    localparam int EV_SYN_W    = 3;
    localparam int EV_TIME_W   = 8;
    localparam int EV_WEIGHT_W = 8;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} disp_state_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous event FIFO storing {addr, time} with occupancy level
// Ports: clk/rst (async active-high), push/wr_addr/wr_time write side,
//        pop/rd_addr/rd_time read side (first-word fall-through),
//        full, empty, level (0..DEPTH)
module event_fifo
    import event_pkg::*;
#(
    parameter int ADDR_W = EV_ADDR_W,
    parameter int TIME_W = EV_TIME_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [TIME_W-1:0]        wr_time,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [TIME_W-1:0]        rd_time,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [ADDR_W+TIME_W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0] wp, rp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= {wr_addr, wr_time};
    end
    assign level = wp - rp;
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign {rd_addr, rd_time} = mem[rp[AW-1:0]];
endmodule

// File: rtl/event_spike_dispatcher.sv
// event_spike_dispatcher: fans buffered spike events out to FANOUT weighted target spikes
// Ports: clk/rst (async active-high), enable (freezes FSM/counters when low),
//        ev_* event input (ready/valid), w_* weight memory port (req/valid),
//        sp_* weighted spike output (ready/valid), ev_done retire pulse,
//        fifo_level occupancy, five saturating activity counters
module event_spike_dispatcher
    import event_pkg::*;
#(
    parameter int ADDR_W   = EV_ADDR_W,
    parameter int SYN_W    = EV_SYN_W,
    parameter int TIME_W   = EV_TIME_W,
    parameter int WEIGHT_W = EV_WEIGHT_W,
    parameter int DEPTH    = 8,
    parameter int FANOUT   = 4,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 32,
    localparam int FO_W    = (FANOUT > 1) ? $clog2(FANOUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [ADDR_W-1:0]         ev_addr,
    input  logic [TIME_W-1:0]         ev_time,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    output logic [ADDR_W+FO_W-1:0]    w_addr,
    output logic                      w_req,
    input  logic [WEIGHT_W-1:0]       w_data,
    input  logic                      w_valid,
    output logic [ADDR_W-SYN_W-1:0]   sp_neuron,
    output logic [2**SYN_W-1:0]       sp_vector,
    output logic [WEIGHT_W-1:0]       sp_weight,
    output logic [TIME_W-1:0]         sp_time,
    output logic                      sp_valid,
    input  logic                      sp_ready,
    output logic                      ev_done,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [CNT_W-1:0]          events_processed,
    output logic [CNT_W-1:0]          spikes_sent,
    output logic [CNT_W-1:0]          weight_timeouts,
    output logic [CNT_W-1:0]          active_cycles,
    output logic [CNT_W-1:0]          idle_cycles
);
    localparam int NW = ADDR_W - SYN_W;
    localparam int VW = 2**SYN_W;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    disp_state_t state, state_n;
    logic [FO_W-1:0]     k, k_n;
    logic [TW-1:0]       timer, timer_n;
    logic [ADDR_W-1:0]   addr_q, addr_n, fifo_addr;
    logic [TIME_W-1:0]   time_q, time_n, fifo_time;
    logic [WEIGHT_W-1:0] weight_q, weight_n;
    logic full, empty, pop, adv, last, emit;
    logic inc_ev, inc_sp, inc_to, inc_act, inc_idle;
    // ev_ready is forced low during reset without waiting for a clock edge
    assign ev_ready = !full && !rst;
    event_fifo #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ev_valid && ev_ready),
        .wr_addr (ev_addr),
        .wr_time (ev_time),
        .pop     (pop),
        .rd_addr (fifo_addr),
        .rd_time (fifo_time),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );
    // Spike fields are zeroed outside EMIT so nothing stale leaks onto the bus
    assign emit      = state == EMIT;
    assign sp_valid  = emit;
    assign sp_neuron = emit ? addr_q[ADDR_W-1:SYN_W] + NW'(k) : '0;
    assign sp_vector = emit ? VW'(1) << addr_q[SYN_W-1:0] : '0;
    assign sp_weight = emit ? weight_q : '0;
    assign sp_time   = emit ? time_q : '0;
    assign w_req     = enable && state == FETCH;
    assign w_addr    = w_req ? {addr_q, k} : '0;
    assign ev_done   = enable && state == DONE;
    assign last      = k == FO_W'(FANOUT - 1);
    assign inc_act   = enable && (state != IDLE || !empty);
    assign inc_idle  = enable && state == IDLE && empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            timer    <= '0;
            addr_q   <= '0;
            time_q   <= '0;
            weight_q <= '0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            timer    <= timer_n;
            addr_q   <= addr_n;
            time_q   <= time_n;
            weight_q <= weight_n;
        end
    end
    always_comb begin
        state_n  = state;
        k_n      = k;
        timer_n  = timer;
        addr_n   = addr_q;
        time_n   = time_q;
        weight_n = weight_q;
        pop      = 1'b0;
        adv      = 1'b0;
        inc_ev   = 1'b0;
        inc_sp   = 1'b0;
        inc_to   = 1'b0;
        if (enable) begin
            case (state)
                IDLE: if (!empty) begin
                    pop     = 1'b1;
                    addr_n  = fifo_addr;
                    time_n  = fifo_time;
                    k_n     = '0;
                    state_n = FETCH;
                end
                FETCH: begin
                    timer_n = '0;
                    state_n = WAIT;
                end
                WAIT: if (w_valid) begin
                    weight_n = w_data;
                    state_n  = (w_data != '0) ? EMIT : state;
                    adv      = w_data == '0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    inc_to = 1'b1;
                    adv    = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
                EMIT: if (sp_ready) begin
                    inc_sp = 1'b1;
                    adv    = 1'b1;
                end
                DONE: begin
                    inc_ev  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            if (adv) begin
                state_n = last ? DONE : FETCH;
                k_n     = last ? k : k + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            events_processed <= '0;
            spikes_sent      <= '0;
            weight_timeouts  <= '0;
            active_cycles    <= '0;
            idle_cycles      <= '0;
        end else begin
            if (inc_ev && !(&events_processed)) events_processed <= events_processed + 1'b1;
            if (inc_sp && !(&spikes_sent)) spikes_sent <= spikes_sent + 1'b1;
            if (inc_to && !(&weight_timeouts)) weight_timeouts <= weight_timeouts + 1'b1;
            if (inc_act && !(&active_cycles)) active_cycles <= active_cycles + 1'b1;
            if (inc_idle && !(&idle_cycles)) idle_cycles <= idle_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_event_spike_dispatcher.sv
// tb_event_spike_dispatcher: directed checks of fan-out, drops, timeouts, backpressure and reset
module tb_event_spike_dispatcher;
    logic clk = 1'b0;
    logic rst, enable, ev_valid, ev_ready, w_req, w_valid, sp_valid, sp_ready, ev_done;
    logic [7:0] ev_addr, ev_time, w_data, sp_weight, sp_time, sp_vector;
    logic [9:0] w_addr;
    logic [4:0] sp_neuron;
    logic [3:0] fifo_level;
    logic [31:0] events_processed, spikes_sent, weight_timeouts, active_cycles, idle_cycles;
    int errors = 0, checks = 0, cyc = 0, done_cnt = 0;
    logic [7:0] weights [4];
    logic hold [4];
    logic pend;
    logic [1:0] pend_k;
    int req_cyc [$];
    logic [4:0] q_n [$];
    logic [7:0] q_v [$], q_w [$], q_t [$];

    always #5 clk = ~clk;

    event_spike_dispatcher dut (
        .clk(clk), .rst(rst), .enable(enable),
        .ev_addr(ev_addr), .ev_time(ev_time), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .w_addr(w_addr), .w_req(w_req), .w_data(w_data), .w_valid(w_valid),
        .sp_neuron(sp_neuron), .sp_vector(sp_vector), .sp_weight(sp_weight), .sp_time(sp_time),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .ev_done(ev_done), .fifo_level(fifo_level),
        .events_processed(events_processed), .spikes_sent(spikes_sent),
        .weight_timeouts(weight_timeouts), .active_cycles(active_cycles), .idle_cycles(idle_cycles)
    );

    // One clock: log handshakes decided at this edge, then act as the weight memory
    task automatic step();
        if (sp_valid && sp_ready && enable) begin
            q_n.push_back(sp_neuron);
            q_v.push_back(sp_vector);
            q_w.push_back(sp_weight);
            q_t.push_back(sp_time);
        end
        if (ev_done) done_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        w_valid = 1'b0;
        if (pend) begin
            w_valid = 1'b1;
            w_data  = weights[pend_k];
            pend    = 1'b0;
        end
        if (w_req) begin
            req_cyc.push_back(cyc);
            if (!hold[w_addr[1:0]]) begin
                pend   = 1'b1;
                pend_k = w_addr[1:0];
            end
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] t);
        ev_addr  = a;
        ev_time  = t;
        ev_valid = 1'b1;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic clear();
        q_n.delete(); q_v.delete(); q_w.delete(); q_t.delete();
        req_cyc.delete();
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) step();
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL wait_done: retired %0d events, required %0d within %0d cycles", done_cnt, target, budget);
        end
    endtask

    task automatic wait_sp(input int budget);
        for (int i = 0; i < budget && !sp_valid; i++) step();
        checks++;
        if (sp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_sp: sp_valid=%b, required 1 within %0d cycles", sp_valid, budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ev_ready !== 1'b0) begin errors++; $display("FAIL rst_ev_ready: got %b expected 0", ev_ready); end
        checks++;
        if ({sp_valid, w_req, ev_done, fifo_level} !== 7'd0) begin
            errors++; $display("FAIL rst_outputs: got %b expected 0", {sp_valid, w_req, ev_done, fifo_level});
        end
        rst = 1'b0;
        step();
        checks++;
        if (ev_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ev_ready: got %b expected 1", ev_ready); end
        repeat (3) step();
        checks++;
        if (idle_cycles !== 32'd4) begin errors++; $display("FAIL idle_cycles: got %0d expected 4", idle_cycles); end
        checks++;
        if (active_cycles !== 32'd0) begin errors++; $display("FAIL active_idle: got %0d expected 0", active_cycles); end
    endtask

    task automatic test_basic();
        int c0;
        clear();
        weights = '{8'h05, 8'h05, 8'h05, 8'h05};
        sp_ready = 1'b1;
        push(8'h2B, 8'h10);
        c0 = cyc;
        repeat (3) step();
        checks++;
        if (sp_valid !== 1'b1 || sp_neuron !== 5'd5) begin
            errors++; $display("FAIL basic_latency: sp_valid=%b neuron=%0d expected 1/5", sp_valid, sp_neuron);
        end
        wait_done(done_cnt + 1, 100);
        checks++;
        if (q_n.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", q_n.size()); end
        for (int i = 0; i < 4 && i < q_n.size(); i++) begin
            checks++;
            if (q_n[i] !== 5'(5 + i) || q_v[i] !== 8'h08 || q_w[i] !== 8'h05 || q_t[i] !== 8'h10) begin
                errors++;
                $display("FAIL basic_spike%0d: got n=%0d v=%h w=%h t=%h expected n=%0d v=08 w=05 t=10",
                         i, q_n[i], q_v[i], q_w[i], q_t[i], 5 + i);
            end
        end
        checks++;
        if (req_cyc.size() < 2 || req_cyc[0] - c0 != 1 || req_cyc[1] - req_cyc[0] != 3) begin
            errors++; $display("FAIL basic_req_timing: got %0d requests, first at +%0d expected +1 spaced 3",
                               req_cyc.size(), req_cyc.size() > 0 ? req_cyc[0] - c0 : -1);
        end
        checks++;
        if (events_processed !== 32'd1 || spikes_sent !== 32'd4) begin
            errors++; $display("FAIL basic_stats: got ev=%0d sp=%0d expected 1/4", events_processed, spikes_sent);
        end
        checks++;
        if (active_cycles !== 32'd14) begin errors++; $display("FAIL basic_active: got %0d expected 14", active_cycles); end
    endtask

    task automatic test_zero_weight();
        logic [4:0] en [3];
        en = '{5'd5, 5'd7, 5'd8};
        clear();
        weights = '{8'h05, 8'h00, 8'h05, 8'h05};
        push(8'h2B, 8'h10);
        wait_done(done_cnt + 1, 100);
        checks++;
        if (q_n.size() != 3) begin errors++; $display("FAIL zero_count: got %0d expected 3", q_n.size()); end
        for (int i = 0; i < 3 && i < q_n.size(); i++) begin
            checks++;
            if (q_n[i] !== en[i]) begin errors++; $display("FAIL zero_neuron%0d: got %0d expected %0d", i, q_n[i], en[i]); end
        end
        checks++;
        if (req_cyc.size() < 3 || req_cyc[2] - req_cyc[1] != 2) begin
            errors++; $display("FAIL zero_req_timing: got %0d requests, expected 4 with 2-cycle drop", req_cyc.size());
        end
        checks++;
        if (weight_timeouts !== 32'd0 || spikes_sent !== 32'd7 || events_processed !== 32'd2) begin
            errors++; $display("FAIL zero_stats: got to=%0d sp=%0d ev=%0d expected 0/7/2",
                               weight_timeouts, spikes_sent, events_processed);
        end
        weights = '{8'h05, 8'h05, 8'h05, 8'h05};
    endtask

    task automatic test_timeout();
        logic [4:0] en [3];
        en = '{5'd5, 5'd6, 5'd8};
        clear();
        hold[2] = 1'b1;
        push(8'h2B, 8'h10);
        wait_done(done_cnt + 1, 100);
        checks++;
        if (q_n.size() != 3) begin errors++; $display("FAIL timeout_count: got %0d expected 3", q_n.size()); end
        for (int i = 0; i < 3 && i < q_n.size(); i++) begin
            checks++;
            if (q_n[i] !== en[i]) begin errors++; $display("FAIL timeout_neuron%0d: got %0d expected %0d", i, q_n[i], en[i]); end
        end
        checks++;
        if (req_cyc.size() < 4 || req_cyc[3] - req_cyc[2] != 16) begin
            errors++; $display("FAIL timeout_wait: got %0d requests, gap %0d expected 16",
                               req_cyc.size(), req_cyc.size() >= 4 ? req_cyc[3] - req_cyc[2] : -1);
        end
        checks++;
        if (weight_timeouts !== 32'd1 || spikes_sent !== 32'd10 || events_processed !== 32'd3) begin
            errors++; $display("FAIL timeout_stats: got to=%0d sp=%0d ev=%0d expected 1/10/3",
                               weight_timeouts, spikes_sent, events_processed);
        end
        hold[2] = 1'b0;
    endtask

    task automatic test_wrap();
        clear();
        push(8'hF8, 8'h33);
        wait_done(done_cnt + 1, 100);
        checks++;
        if (q_n.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", q_n.size()); end
        for (int i = 0; i < 4 && i < q_n.size(); i++) begin
            checks++;
            if (q_n[i] !== 5'(31 + i) || q_v[i] !== 8'h01 || q_t[i] !== 8'h33) begin
                errors++; $display("FAIL wrap_spike%0d: got n=%0d v=%h t=%h expected n=%0d v=01 t=33",
                                   i, q_n[i], q_v[i], q_t[i], 5'(31 + i));
            end
        end
    endtask

    task automatic test_enable();
        int base;
        clear();
        base = done_cnt;
        sp_ready = 1'b0;
        push(8'h10, 8'h01);
        wait_sp(20);
        enable = 1'b0;
        sp_ready = 1'b1;
        push(8'h21, 8'h02);
        repeat (2) step();
        checks++;
        if (sp_valid !== 1'b1 || spikes_sent !== 32'd14 || q_n.size() != 0) begin
            errors++; $display("FAIL enable_freeze: got sp_valid=%b sent=%0d expected 1/14", sp_valid, spikes_sent);
        end
        checks++;
        if (fifo_level !== 4'd1) begin errors++; $display("FAIL enable_fifo_fill: got %0d expected 1", fifo_level); end
        enable = 1'b1;
        wait_done(base + 2, 200);
        checks++;
        if (q_n.size() != 8 || q_n[0] !== 5'd2 || q_n[4] !== 5'd4 || q_v[4] !== 8'h02) begin
            errors++; $display("FAIL enable_resume: got %0d spikes n0=%0d n4=%0d expected 8/2/4", q_n.size(), q_n[0], q_n[4]);
        end
        checks++;
        if (spikes_sent !== 32'd22 || events_processed !== 32'd6) begin
            errors++; $display("FAIL enable_stats: got sp=%0d ev=%0d expected 22/6", spikes_sent, events_processed);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        clear();
        base = done_cnt;
        sp_ready = 1'b0;
        push(8'h50, 8'hAA);
        wait_sp(20);
        for (int j = 0; j < 8; j++) push(8'((j << 3) | j), 8'(8'h20 + j));
        checks++;
        if (fifo_level !== 4'd8 || ev_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_full: got level=%0d ev_ready=%b expected 8/0", fifo_level, ev_ready);
        end
        push(8'hFF, 8'hFF);
        checks++;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL b2b_refuse: got level %0d expected 8", fifo_level); end
        checks++;
        if (sp_valid !== 1'b1 || sp_neuron !== 5'd10 || sp_time !== 8'hAA || sp_vector !== 8'h01 || sp_weight !== 8'h05) begin
            errors++; $display("FAIL b2b_hold: got v=%b n=%0d t=%h vec=%h w=%h expected 1/10/AA/01/05",
                               sp_valid, sp_neuron, sp_time, sp_vector, sp_weight);
        end
        clear();
        sp_ready = 1'b1;
        wait_done(base + 9, 500);
        checks++;
        if (q_n.size() != 36) begin errors++; $display("FAIL b2b_count: got %0d expected 36", q_n.size()); end
        for (int e = 0; e < 9 && 4 * e < q_n.size(); e++) begin
            logic [4:0] xn;
            logic [7:0] xt, xv;
            xn = (e == 0) ? 5'd10 : 5'(e - 1);
            xt = (e == 0) ? 8'hAA : 8'(8'h20 + e - 1);
            xv = (e == 0) ? 8'h01 : 8'(1 << (e - 1));
            checks++;
            if (q_n[4*e] !== xn || q_t[4*e] !== xt || q_v[4*e] !== xv) begin
                errors++; $display("FAIL b2b_order%0d: got n=%0d t=%h v=%h expected n=%0d t=%h v=%h",
                                   e, q_n[4*e], q_t[4*e], q_v[4*e], xn, xt, xv);
            end
        end
        checks++;
        if (fifo_level !== 4'd0 || spikes_sent !== 32'd58 || events_processed !== 32'd15) begin
            errors++; $display("FAIL b2b_stats: got level=%0d sp=%0d ev=%0d expected 0/58/15",
                               fifo_level, spikes_sent, events_processed);
        end
    endtask

    task automatic test_reset_mid();
        sp_ready = 1'b0;
        push(8'h2B, 8'h10);
        push(8'h11, 8'h22);
        wait_sp(20);
        rst = 1'b1;
        #1;
        checks++;
        if ({sp_valid, sp_neuron, sp_vector, sp_weight, sp_time} !== 30'd0) begin
            errors++; $display("FAIL mid_rst_sp: got v=%b n=%0d vec=%h w=%h t=%h expected all 0",
                               sp_valid, sp_neuron, sp_vector, sp_weight, sp_time);
        end
        checks++;
        if ({w_req, w_addr, ev_done, ev_ready, fifo_level} !== 17'd0) begin
            errors++; $display("FAIL mid_rst_ctl: got req=%b addr=%h done=%b rdy=%b lvl=%0d expected all 0",
                               w_req, w_addr, ev_done, ev_ready, fifo_level);
        end
        checks++;
        if (events_processed !== 32'd0 || spikes_sent !== 32'd0 || active_cycles !== 32'd0 || idle_cycles !== 32'd0) begin
            errors++; $display("FAIL mid_rst_cnt: got ev=%0d sp=%0d act=%0d idle=%0d expected 0",
                               events_processed, spikes_sent, active_cycles, idle_cycles);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 1'b0;
        w_valid = 1'b0;
        clear();
        sp_ready = 1'b1;
        push(8'h2B, 8'h10);
        wait_done(done_cnt + 1, 100);
        checks++;
        if (q_n.size() != 4 || q_n[0] !== 5'd5 || q_n[3] !== 5'd8) begin
            errors++; $display("FAIL mid_rst_resume: got %0d spikes n0=%0d expected 4 from 5", q_n.size(), q_n[0]);
        end
        checks++;
        if (events_processed !== 32'd1 || spikes_sent !== 32'd4) begin
            errors++; $display("FAIL mid_rst_stats: got ev=%0d sp=%0d expected 1/4", events_processed, spikes_sent);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; ev_valid = 1'b0; ev_addr = '0; ev_time = '0;
        w_valid = 1'b0; w_data = '0; sp_ready = 1'b0; pend = 1'b0; pend_k = '0;
        weights = '{8'h05, 8'h05, 8'h05, 8'h05};
        hold = '{1'b0, 1'b0, 1'b0, 1'b0};
        test_reset();
        test_basic();
        test_zero_weight();
        test_timeout();
        test_wrap();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule

// File: doc/event_spike_dispatcher.md
# event_spike_dispatcher

Parametrised event-driven spike dispatcher for the neuromorphic datapath. Incoming spike events are buffered in an internal FIFO. Each event fans out to FANOUT consecutive target neurons, with one synaptic weight fetched per target over a request/valid memory port. Weighted spikes leave on a ready/valid output. The block drops zero-weight synapses, tolerates slow or missing memory responses through a timeout, and keeps saturating activity statistics for power accounting.

## Interface
Parameters:
- ADDR_W, 8, event address width; upper ADDR_W-SYN_W bits select neuron, low SYN_W bits select synapse lane
- SYN_W, 3, synapse-lane index width; spike vector is 2**SYN_W bits
- TIME_W, 8, timestamp width
- WEIGHT_W, 8, weight width
- DEPTH, 8, event FIFO depth (power of two, ≥2)
- FANOUT, 4, targets per event (power of two, ≥1); FO_W = max(1, log2(FANOUT))
- TIMEOUT, 15, max cycles waiting for w_valid
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  advances the FSM; FIFO pushes are accepted regardless
- ev_addr  in  ADDR_W  event source address
- ev_time  in  TIME_W  event timestamp
- ev_valid  in  1  event offered
- ev_ready  out  1  FIFO not full; forced 0 while rst is high
- w_addr  out  ADDR_W+FO_W  weight address {ev_addr, k}
- w_req  out  1  one-cycle weight read request
- w_data  in  WEIGHT_W  weight returned
- w_valid  in  1  weight data valid
- sp_neuron  out  ADDR_W-SYN_W  target neuron
- sp_vector  out  2**SYN_W  one-hot synapse lane
- sp_weight  out  WEIGHT_W  synaptic weight
- sp_time  out  TIME_W  event timestamp carried through
- sp_valid  out  1  spike offered
- sp_ready  in  1  downstream accepts
- ev_done  out  1  one-cycle pulse per retired event
- fifo_level  out  log2(DEPTH)+1  FIFO occupancy
- events_processed, spikes_sent, weight_timeouts, active_cycles, idle_cycles  out  CNT_W each  saturating statistics counters

## Operation
- FIFO push on ev_valid && ev_ready. There is no bypass, so a pushed event is visible to the FSM the next cycle.
- FSM states: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE: if the FIFO is non-empty, pop it, latch addr and time, set k=0, go to FETCH.
- FETCH: drive w_addr={addr,k} and w_req=1 for one cycle, clear the timer, go to WAIT.
- WAIT:
  - If w_valid: latch w_data. Go to EMIT if the weight is non-zero, otherwise advance.
  - Else if timer==TIMEOUT-1: increment weight_timeouts and advance.
  - Else increment the timer.
  - w_valid arriving outside WAIT is ignored.
- EMIT: present the spike and hold all sp_* outputs stable until sp_valid && sp_ready, then increment spikes_sent and advance.
- Advance: if k==FANOUT-1 go to DONE, else k=k+1 and go to FETCH.
- DONE: pulse ev_done, increment events_processed, go to IDLE.
- Target neuron = addr[ADDR_W-1:SYN_W] + k, modulo 2**(ADDR_W-SYN_W), so the target wraps past the top neuron.
- sp_vector = 1 << addr[SYN_W-1:0].
- enable=0:
  - FSM, timer and counters are frozen.
  - EMIT keeps sp_valid high, but no handshake is counted until enable returns.
  - The FIFO still fills.
- active_cycles increments when enable and state≠IDLE, or when IDLE pops.
- idle_cycles increments when enable and IDLE with the FIFO empty.
- All counters saturate at all-ones.

## Timing
- Reset (asynchronous, any state, mid-event included):
  - FSM goes to IDLE and the FIFO empties.
  - Every output and counter goes to 0, including sp_*, w_*, ev_done and fifo_level.
  - ev_ready is 1 from the first cycle after reset deasserts.
- Minimum latency, with FANOUT=1, w_valid the cycle after w_req, and sp_ready=1:
  - Push at cycle N.
  - Pop at N+1.
  - w_req at N+2.
  - w_valid in WAIT at N+3.
  - sp_valid at N+4.
  - ev_done at N+5.
- Each synapse costs at least 3 cycles; a zero weight costs 2.
- Full FIFO: ev_ready=0, so a push in the same cycle as a pop is refused (ev_ready does not look ahead).
- Empty FIFO: IDLE waits with no pop.

## Structure
- Shared package event_pkg holds the FSM state enum and the default width constants (ADDR_W, SYN_W, TIME_W, WEIGHT_W).
- Sub-module event_fifo: synchronous FIFO with async reset, DEPTH×(ADDR_W+TIME_W) storage, full, empty and level outputs. It is instantiated once.

## Test plan
- Reset, then push addr=0x2B, time=0x10, FANOUT=4, all weights 0x05, sp_ready=1 → 4 spikes on neurons 5,6,7,8, sp_vector=0x08, sp_time=0x10, one ev_done, events_processed=1, spikes_sent=4.
- Weight for k=1 is 0 → only 3 spikes; neuron 6 is skipped and there is no timeout.
- w_valid withheld for k=2 → after 15 WAIT cycles weight_timeouts=1, 3 spikes sent, event retires.
- Push 9 events back-to-back with sp_ready=0 → ev_ready drops after the 8th push (level=8, 9th not accepted), sp_valid is held stable; raising sp_ready drains all 8 events in order.
- addr=0xF8, FANOUT=4 → targets 31,0,1,2 (wrap-around).
- Assert rst during EMIT → all outputs 0 immediately, fifo_level=0, and a subsequent single event processes normally.
